muldiv_seq: RTL and testbench
=============================

Name: muldiv_seq

Overview:
- Iterative multiply/divide sequencer and HI/LO register owner for the pipelined MIPS core.
- Launched from the Execute stage by the multordiv/hlwrite control path. Runs mult, multu, div and divu over WIDTH+1 cycles.
- Raises a stall request to the hazard unit while busy, so the pipeline does not issue a new mul/div or read HI/LO early.
- Also services mthi/mtlo writes and supplies HI/LO to the mfhi/mflo writeback path.

Parameters:
- WIDTH, 32, operand width and HI/LO register width; the iteration count equals WIDTH.

Ports:
- clk  in  1  core clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- startE  in  1  launch operation (multordivE & ~flushE).
- opE  in  2  00 mult, 01 multu, 10 div, 11 divu.
- srcaE  in  WIDTH  rs operand (multiplicand / dividend).
- srcbE  in  WIDTH  rt operand (multiplier / divisor).
- mthiE  in  1  write srcaE into HI.
- mtloE  in  1  write srcaE into LO.
- mdopD  in  1  Decode holds mult/div/mthi/mtlo.
- readhiloD  in  1  Decode holds mfhi/mflo.
- hi  out  WIDTH  HI register.
- lo  out  WIDTH  LO register.
- busy  out  1  sequencer not IDLE.
- stallD  out  1  busy & (mdopD | readhiloD).
- done  out  1  one-cycle pulse in the cycle after HI/LO update.

Behaviour:
- Reset (async): state=IDLE, hi=0, lo=0, busy=0, done=0, counter=0, internal accumulators=0. Reset mid-operation abandons the operation with no partial HI/LO update.
- States: IDLE, RUN, FIX.
- IDLE, startE=1: latch operand magnitudes (absolute values for signed ops, raw for unsigned), sign flags and op. Clear accumulator, counter=0, go to RUN.
- IDLE, mthiE/mtloE: write hi/lo at this edge. If startE coincides with either write, startE wins and the write is dropped (the decoder never issues both).
- RUN: one radix-2 step per cycle.
  - Multiply: shift-add, producing a 2*WIDTH unsigned product.
  - Divide: restoring, producing a WIDTH quotient and a WIDTH remainder.
  - Counter increments each cycle; after WIDTH steps (counter==WIDTH-1 at edge) go to FIX.
- FIX, one cycle, fixup and commit:
  - mult: negate the product if the operand signs differ.
  - div: negate the quotient if the signs differ; negate the remainder if the dividend was negative.
  - Commit: multiply writes hi=product[2W-1:W], lo=product[W-1:0]. Divide writes lo=quotient, hi=remainder.
  - Go to IDLE; done=1 next cycle.
- Latency: start edge at cycle 0; hi/lo valid after edge WIDTH+1 (33 for W=32). busy high cycles 1..WIDTH+1.
- busy is registered; it is low in the cycle startE is sampled. The hazard unit uses stallD, which covers the following instructions.
- Divide by zero (divisor==0, any op):
  - Same latency as a normal divide.
  - lo = all ones; hi = original srcaE, unsigned bit pattern.
  - Required for both div and divu.
- Signed overflow 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0.
- startE, mthiE or mtloE asserted while busy: ignored. A protocol violation; stallD prevents it in normal flow.
- hi/lo are not modified during RUN; they hold old values until the FIX commit.
- Arithmetic is unsigned internally; negation is two's complement at WIDTH (product at 2*WIDTH).

Test Plan:
- multu 0xFFFFFFFF × 0xFFFFFFFF -> after 33 cycles hi=0xFFFFFFFE, lo=0x00000001; done pulse at cycle 34; busy cycles 1-33.
- mult -3 × 7 (0xFFFFFFFD, 0x7) -> hi=0xFFFFFFFF, lo=0xFFFFFFEB.
- div -7 / 2 -> lo=0xFFFFFFFD (−3), hi=0xFFFFFFFF (−1); divu 7 / 2 -> lo=3, hi=1.
- div 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0. divu 0x1234 / 0 -> lo=0xFFFFFFFF, hi=0x1234.
- Hazards:
  - readhiloD=1 during busy -> stallD=1 every cycle until the FIX commit, then 0.
  - mthiE with srcaE=0xCAFEBABE in IDLE -> hi=0xCAFEBABE next cycle, lo unchanged.
  - mtloE during busy -> ignored.
- Assert reset at cycle 10 of a mult -> hi=lo=0 immediately, busy=0, no done pulse. A new startE after reset release completes normally.

Source files
------------

// File: rtl/muldiv_seq_if.sv
// Execute/Decode-side signals of the mul/div sequencer: launch controls,
// HI/LO write-back and the hazard outputs.
interface muldiv_seq_if #(parameter int WIDTH = 32);
  logic             startE;
  logic [1:0]       opE;
  logic [WIDTH-1:0] srcaE;
  logic [WIDTH-1:0] srcbE;
  logic             mthiE;
  logic             mtloE;
  logic             mdopD;
  logic             readhiloD;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic             busy;
  logic             stallD;
  logic             done;

  modport master (
    output startE, opE, srcaE, srcbE, mthiE, mtloE, mdopD, readhiloD,
    input  hi, lo, busy, stallD, done
  );

  modport slave (
    input  startE, opE, srcaE, srcbE, mthiE, mtloE, mdopD, readhiloD,
    output hi, lo, busy, stallD, done
  );
endinterface

// File: rtl/muldiv_seq.sv
// Iterative radix-2 multiply/divide unit owning HI/LO. Runs on operand
// magnitudes for WIDTH steps, then fixes signs and commits in one FIX cycle.
module muldiv_seq #(
  parameter int WIDTH = 32
) (
  input logic         clk,
  input logic         reset,
  muldiv_seq_if.slave bus
);
  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;
  state_t state, stateNext;

  logic [CW-1:0]    count;
  logic [WIDTH-1:0] accHi, accLo, opB;
  logic [WIDTH-1:0] hiReg, loReg;
  logic             isDiv, negA, negRes, divZero, doneReg;

  logic             signedOp, signA, signB;
  logic [WIDTH-1:0] magA, magB;
  logic [WIDTH:0]   mulSum;
  logic [WIDTH:0]   remShift;
  logic [WIDTH-1:0] divDiff;
  logic             divGe;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0] quot, rem;

  assign signedOp = ~bus.opE[0];
  assign signA    = signedOp & bus.srcaE[WIDTH-1];
  assign signB    = signedOp & bus.srcbE[WIDTH-1];
  assign magA     = signA ? -bus.srcaE : bus.srcaE;
  assign magB     = signB ? -bus.srcbE : bus.srcbE;

  // Multiply: accLo holds the multiplier and fills with product bits from the top.
  assign mulSum   = accLo[0] ? ({1'b0, accHi} + {1'b0, opB}) : {1'b0, accHi};

  // Restoring divide: partial remainder is always < divisor, so it fits WIDTH bits.
  assign remShift = {accHi, accLo[WIDTH-1]};
  assign divGe    = remShift >= {1'b0, opB};
  assign divDiff  = remShift[WIDTH-1:0] - opB;

  assign prod = negRes ? -{accHi, accLo} : {accHi, accLo};
  assign quot = divZero ? '1 : (negRes ? -accLo : accLo);
  assign rem  = negA ? -accHi : accHi;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= stateNext;
  end

  always_comb begin
    stateNext = state;
    case (state)
      IDLE:    if (bus.startE) stateNext = RUN;
      RUN:     if (count == CW'(WIDTH - 1)) stateNext = FIX;
      FIX:     stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count   <= '0;
      accHi   <= '0;
      accLo   <= '0;
      opB     <= '0;
      hiReg   <= '0;
      loReg   <= '0;
      isDiv   <= 1'b0;
      negA    <= 1'b0;
      negRes  <= 1'b0;
      divZero <= 1'b0;
      doneReg <= 1'b0;
    end else begin
      doneReg <= (state == FIX);
      case (state)
        IDLE: begin
          if (bus.startE) begin
            accHi   <= '0;
            accLo   <= magA;
            opB     <= magB;
            isDiv   <= bus.opE[1];
            negA    <= signA;
            negRes  <= signA ^ signB;
            divZero <= (bus.srcbE == '0);
            count   <= '0;
          end else begin
            if (bus.mthiE) hiReg <= bus.srcaE;
            if (bus.mtloE) loReg <= bus.srcaE;
          end
        end
        RUN: begin
          count <= count + 1'b1;
          if (isDiv) begin
            accHi <= divGe ? divDiff : remShift[WIDTH-1:0];
            accLo <= {accLo[WIDTH-2:0], divGe};
          end else begin
            accHi <= mulSum[WIDTH:1];
            accLo <= {mulSum[0], accLo[WIDTH-1:1]};
          end
        end
        FIX: begin
          if (isDiv) begin
            loReg <= quot;
            hiReg <= rem;
          end else begin
            hiReg <= prod[2*WIDTH-1:WIDTH];
            loReg <= prod[WIDTH-1:0];
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.hi     = hiReg;
  assign bus.lo     = loReg;
  assign bus.busy   = (state != IDLE);
  assign bus.stallD = bus.busy & (bus.mdopD | bus.readhiloD);
  assign bus.done   = doneReg;
endmodule

// File: tb/tb_muldiv_seq.sv
// Directed bench for muldiv_seq: vector table for results and latency, plus
// hand sequences for HI/LO writes, hazards and mid-operation reset.
module tb_muldiv_seq;
  localparam int W = 32;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  muldiv_seq_if #(.WIDTH(W)) bus();
  muldiv_seq #(.WIDTH(W)) dut (.clk(clk), .reset(reset), .bus(bus));

  int total = 0;
  int bad = 0;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] expHi;
    logic [31:0] expLo;
    string       name;
  } vec_t;

  vec_t vecs[13];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic runOp(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       input bit injMtlo, output int busyCnt, output int stallCnt,
                       output bit doneSeen, output bit heldOk);
    logic [31:0] h0, l0;
    @(negedge clk);
    h0 = bus.hi;
    l0 = bus.lo;
    bus.opE = op;
    bus.srcaE = a;
    bus.srcbE = b;
    bus.startE = 1'b1;
    @(negedge clk);
    bus.startE = 1'b0;
    busyCnt = 0;
    stallCnt = 0;
    doneSeen = 1'b0;
    heldOk = 1'b1;
    for (int c = 0; c < 100 && !doneSeen; c++) begin
      if (bus.done) doneSeen = 1'b1;
      else begin
        if (bus.busy) busyCnt++;
        if (bus.stallD) stallCnt++;
        if (bus.hi !== h0 || bus.lo !== l0) heldOk = 1'b0;
        if (injMtlo && c == 5) begin
          bus.mtloE = 1'b1;
          bus.mthiE = 1'b1;
          bus.startE = 1'b1;
          bus.srcaE = 32'h5555_5555;
        end else begin
          bus.mtloE = 1'b0;
          bus.mthiE = 1'b0;
          bus.startE = 1'b0;
        end
        @(negedge clk);
      end
    end
  endtask

  initial begin
    int busyCnt, stallCnt, doneHits;
    bit doneSeen, heldOk;
    logic [31:0] lastLo;

    vecs[0]  = '{2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, "multu_max"};
    vecs[1]  = '{2'b00, 32'hFFFF_FFFD, 32'h0000_0007, 32'hFFFF_FFFF, 32'hFFFF_FFEB, "mult_m3x7"};
    vecs[2]  = '{2'b10, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD, "div_m7d2"};
    vecs[3]  = '{2'b11, 32'h0000_0007, 32'h0000_0002, 32'h0000_0001, 32'h0000_0003, "divu_7d2"};
    vecs[4]  = '{2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, "div_ovf"};
    vecs[5]  = '{2'b11, 32'h0000_1234, 32'h0000_0000, 32'h0000_1234, 32'hFFFF_FFFF, "divu_by0"};
    vecs[6]  = '{2'b10, 32'hFFFF_FFF9, 32'h0000_0000, 32'hFFFF_FFF9, 32'hFFFF_FFFF, "div_neg_by0"};
    vecs[7]  = '{2'b00, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, "mult_min_sq"};
    vecs[8]  = '{2'b00, 32'h0000_0007, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'hFFFF_FFF2, "mult_7xm2"};
    vecs[9]  = '{2'b10, 32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, "div_7dm2"};
    vecs[10] = '{2'b01, 32'h1234_5678, 32'h0000_0010, 32'h0000_0001, 32'h2345_6780, "multu_x16"};
    vecs[11] = '{2'b11, 32'h0000_0064, 32'h0000_0007, 32'h0000_0002, 32'h0000_000E, "divu_100d7"};
    vecs[12] = '{2'b10, 32'h0000_0000, 32'h0000_0005, 32'h0000_0000, 32'h0000_0000, "div_0d5"};

    bus.startE = 0; bus.opE = 0; bus.srcaE = 0; bus.srcbE = 0;
    bus.mthiE = 0; bus.mtloE = 0; bus.mdopD = 0; bus.readhiloD = 0;

    repeat (2) @(negedge clk);
    check("rst_hi", bus.hi, 32'h0);
    check("rst_lo", bus.lo, 32'h0);
    check("rst_busy", {31'b0, bus.busy}, 32'h0);
    check("rst_done", {31'b0, bus.done}, 32'h0);
    reset = 1'b0;

    for (int i = 0; i < 13; i++) begin
      runOp(vecs[i].op, vecs[i].a, vecs[i].b, 1'b0, busyCnt, stallCnt, doneSeen, heldOk);
      check({vecs[i].name, "_done"}, {31'b0, doneSeen}, 32'h1);
      check({vecs[i].name, "_hi"}, bus.hi, vecs[i].expHi);
      check({vecs[i].name, "_lo"}, bus.lo, vecs[i].expLo);
      check({vecs[i].name, "_busycyc"}, busyCnt, 33);
      check({vecs[i].name, "_hold"}, {31'b0, heldOk}, 32'h1);
      check({vecs[i].name, "_busyoff"}, {31'b0, bus.busy}, 32'h0);
      @(negedge clk);
      check({vecs[i].name, "_donepulse"}, {31'b0, bus.done}, 32'h0);
    end

    // mthi in IDLE: hi updates, lo keeps the last result
    lastLo = bus.lo;
    bus.mthiE = 1'b1;
    bus.srcaE = 32'hCAFE_BABE;
    @(negedge clk);
    bus.mthiE = 1'b0;
    check("mthi_hi", bus.hi, 32'hCAFE_BABE);
    check("mthi_lo", bus.lo, lastLo);
    bus.mtloE = 1'b1;
    bus.srcaE = 32'h0BAD_F00D;
    @(negedge clk);
    bus.mtloE = 1'b0;
    check("mtlo_lo", bus.lo, 32'h0BAD_F00D);
    check("mtlo_hi", bus.hi, 32'hCAFE_BABE);

    // hazard: stall during the whole operation, released at commit
    bus.readhiloD = 1'b1;
    runOp(2'b11, 32'h7, 32'h2, 1'b0, busyCnt, stallCnt, doneSeen, heldOk);
    check("stall_cycles", stallCnt, 33);
    check("stall_release", {31'b0, bus.stallD}, 32'h0);
    check("stall_lo", bus.lo, 32'h3);
    bus.readhiloD = 1'b0;

    // mthi/mtlo/startE while busy are ignored
    runOp(2'b01, 32'h3, 32'h5, 1'b1, busyCnt, stallCnt, doneSeen, heldOk);
    check("busywr_hold", {31'b0, heldOk}, 32'h1);
    check("busywr_hi", bus.hi, 32'h0);
    check("busywr_lo", bus.lo, 32'hF);
    check("busywr_busycyc", busyCnt, 33);

    // reset in the middle of a multiply
    @(negedge clk);
    bus.opE = 2'b00; bus.srcaE = 32'hFFFF_FFFD; bus.srcbE = 32'h7; bus.startE = 1'b1;
    @(negedge clk);
    bus.startE = 1'b0;
    repeat (9) @(negedge clk);
    reset = 1'b1;
    #1;
    check("midrst_hi", bus.hi, 32'h0);
    check("midrst_lo", bus.lo, 32'h0);
    check("midrst_busy", {31'b0, bus.busy}, 32'h0);
    doneHits = 0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      if (bus.done) doneHits++;
    end
    reset = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (bus.done) doneHits++;
    end
    check("midrst_nodone", doneHits, 0);
    check("midrst_lo_after", bus.lo, 32'h0);
    runOp(2'b00, 32'hFFFF_FFFD, 32'h7, 1'b0, busyCnt, stallCnt, doneSeen, heldOk);
    check("postrst_done", {31'b0, doneSeen}, 32'h1);
    check("postrst_hi", bus.hi, 32'hFFFF_FFFF);
    check("postrst_lo", bus.lo, 32'hFFFF_FFEB);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
